mem_bank_arbiter: RTL and testbench

MEM_BANK_ARBITER -- requirements
Module: mem_bank_arbiter

---
 rtl/mem_bank_arbiter_if.sv | 30 +++
 rtl/mem_bank_arbiter.sv | 131 +++++++++++++
 tb/tb_mem_bank_arbiter.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_bank_arbiter_if.sv
// Requester-side and bank-side signals of the banked memory arbiter, flattened per port.
interface mem_bank_arbiter_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBANK = 16
);
  logic [NREQ-1:0]     req_valid;
  logic [NREQ-1:0]     req_we;
  logic [NREQ*16-1:0]  req_addr;
  logic [NREQ*16-1:0]  req_wdata;
  logic [NREQ-1:0]     req_gnt;
  logic [NREQ-1:0]     rsp_valid;
  logic [NREQ*16-1:0]  rsp_data;
  logic [NBANK-1:0]    bank_en;
  logic [NBANK-1:0]    bank_we;
  logic [NBANK*11-1:0] bank_addr;
  logic [NBANK*16-1:0] bank_wdata;
  logic [NBANK*16-1:0] bank_rdata;

  // Arbiter side.
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, bank_rdata,
    output req_gnt, rsp_valid, rsp_data, bank_en, bank_we, bank_addr, bank_wdata
  );

  // Requesters plus memory banks.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, bank_rdata,
    input  req_gnt, rsp_valid, rsp_data, bank_en, bank_we, bank_addr, bank_wdata
  );
endinterface

// File: rtl/mem_bank_arbiter.sv
// Per-bank round-robin arbiter for NREQ requesters over NBANK halfword-interleaved banks,
// with a 2-stage tag pipeline routing read data back to the winning requester.
module mem_bank_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned NBANK = 16
) (
  input logic               clk,
  input logic               rst,
  mem_bank_arbiter_if.slave bus
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned BW = $clog2(NBANK);

  logic [15:0]      w_addr  [NREQ];
  logic [15:0]      w_wdata [NREQ];
  logic [BW-1:0]    w_sel   [NREQ];
  logic [NREQ-1:0]  w_unused_addr_lsb;

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign w_addr[i]            = bus.req_addr[i*16 +: 16];
    assign w_wdata[i]           = bus.req_wdata[i*16 +: 16];
    assign w_sel[i]             = w_addr[i][BW:1];
    assign w_unused_addr_lsb[i] = w_addr[i][0];
  end

  logic [IW-1:0]    r_ptr [NBANK];
  logic [NBANK-1:0] r_v1;
  logic [NBANK-1:0] r_v2;
  logic [IW-1:0]    r_id1 [NBANK];
  logic [IW-1:0]    r_id2 [NBANK];

  logic [NREQ-1:0]  w_gnt;
  logic [NBANK-1:0] w_hit;
  logic [IW-1:0]    w_win [NBANK];

  // Each requester targets exactly one bank, so it can win at most one grant per cycle.
  always_comb begin
    int unsigned l_idx;
    logic [IW-1:0] l_id;
    l_idx = 0;
    l_id  = '0;
    w_gnt = '0;
    w_hit = '0;
    for (int b = 0; b < NBANK; b++) begin
      w_win[b] = '0;
      if (!rst) begin
        for (int unsigned k = 0; k < NREQ; k++) begin
          l_idx = 32'(r_ptr[b]) + k;
          if (l_idx >= NREQ) begin
            l_idx = l_idx - NREQ;
          end
          l_id = IW'(l_idx);
          if (!w_hit[b] && bus.req_valid[l_id] && (w_sel[l_id] == BW'(b))) begin
            w_hit[b]    = 1'b1;
            w_gnt[l_id] = 1'b1;
            w_win[b]    = l_id;
          end
        end
      end
    end
  end

  logic [NBANK-1:0]    w_bank_we;
  logic [NBANK*11-1:0] w_bank_addr;
  logic [NBANK*16-1:0] w_bank_wdata;

  always_comb begin
    w_bank_we    = '0;
    w_bank_addr  = '0;
    w_bank_wdata = '0;
    for (int b = 0; b < NBANK; b++) begin
      if (w_hit[b]) begin
        w_bank_we[b]              = bus.req_we[w_win[b]];
        w_bank_addr[b*11 +: 11]   = w_addr[w_win[b]][15:5];
        w_bank_wdata[b*16 +: 16]  = w_wdata[w_win[b]];
      end
    end
  end

  assign bus.req_gnt    = w_gnt;
  assign bus.bank_en    = w_hit;
  assign bus.bank_we    = w_bank_we;
  assign bus.bank_addr  = w_bank_addr;
  assign bus.bank_wdata = w_bank_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1 <= '0;
      r_v2 <= '0;
      for (int b = 0; b < NBANK; b++) begin
        r_ptr[b] <= '0;
        r_id1[b] <= '0;
        r_id2[b] <= '0;
      end
    end else begin
      r_v2 <= r_v1;
      for (int b = 0; b < NBANK; b++) begin
        r_v1[b]  <= w_hit[b] & ~w_bank_we[b];
        r_id1[b] <= w_win[b];
        r_id2[b] <= r_id1[b];
        if (w_hit[b]) begin
          r_ptr[b] <= (w_win[b] == IW'(NREQ - 1)) ? '0 : w_win[b] + IW'(1);
        end
      end
    end
  end

  logic [NREQ-1:0] w_rsp_valid;
  logic [15:0]     w_rsp_word [NREQ];

  // At most one bank can carry a tag for a given requester, so plain assignment suffices.
  always_comb begin
    w_rsp_valid = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_rsp_word[i] = '0;
    end
    for (int b = 0; b < NBANK; b++) begin
      if (r_v2[b]) begin
        w_rsp_valid[r_id2[b]] = 1'b1;
        w_rsp_word[r_id2[b]]  = bus.bank_rdata[b*16 +: 16];
      end
    end
  end

  assign bus.rsp_valid = w_rsp_valid;

  for (genvar i = 0; i < NREQ; i++) begin : g_rsp_pack
    assign bus.rsp_data[i*16 +: 16] = w_rsp_word[i];
  end

endmodule

// File: tb/tb_mem_bank_arbiter.sv
// Directed bench for mem_bank_arbiter: bank memory model, read scoreboard, grant checks.
module tb_mem_bank_arbiter;
  localparam int unsigned NREQ  = 4;
  localparam int unsigned NBANK = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_bank_arbiter_if #(.NREQ(NREQ), .NBANK(NBANK)) bus ();
  mem_bank_arbiter #(.NREQ(NREQ), .NBANK(NBANK)) dut (.clk(clk), .rst(rst), .bus(bus));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  function automatic logic [15:0] pat(input int b, input int w);
    return 16'((b * 4099 + w * 37) ^ 23205);
  endfunction

  // Memories store value ^ pattern, so untouched words read back as the pattern.
  bit   [15:0]      mem     [NBANK][2048];
  bit   [15:0]      ref_mem [NBANK][2048];
  logic [15:0]      rd1 [NBANK];
  logic [15:0]      rd2 [NBANK];
  logic [NBANK-1:0] cap_en = '0;
  logic [NBANK-1:0] cap_we = '0;
  logic [10:0]      cap_addr  [NBANK];
  logic [15:0]      cap_wdata [NBANK];

  always @(posedge clk) begin
    for (int b = 0; b < NBANK; b++) begin
      rd2[b] <= rd1[b];
      rd1[b] <= (cap_en[b] && !cap_we[b]) ?
                (mem[b][cap_addr[b]] ^ pat(b, int'(cap_addr[b]))) : 16'hDEAD;
      if (cap_en[b] && cap_we[b]) mem[b][cap_addr[b]] <= cap_wdata[b] ^ pat(b, int'(cap_addr[b]));
    end
  end

  always_comb begin
    bus.bank_rdata = '0;
    for (int b = 0; b < NBANK; b++) bus.bank_rdata[b*16 +: 16] = rd2[b];
  end

  typedef struct {
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sbq [NREQ][$];

  logic [NREQ-1:0]     s_gnt;
  logic [NREQ-1:0]     s_rsp_v;
  logic [NREQ*16-1:0]  s_rsp_d;
  logic [NBANK-1:0]    s_en;
  logic [NBANK-1:0]    s_we;
  logic [NBANK*11-1:0] s_addr;
  logic [NBANK*16-1:0] s_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Samples at the falling edge, runs the scoreboard, then returns just after the next rise.
  task automatic step();
    logic exp_v;
    int   b;
    int   w;
    @(negedge clk);
    cyc++;
    s_gnt   = bus.req_gnt;
    s_rsp_v = bus.rsp_valid;
    s_rsp_d = bus.rsp_data;
    s_en    = bus.bank_en;
    s_we    = bus.bank_we;
    s_addr  = bus.bank_addr;
    s_wdata = bus.bank_wdata;
    cap_en  = s_en;
    cap_we  = s_we;
    for (int k = 0; k < NBANK; k++) begin
      cap_addr[k]  = s_addr[k*11 +: 11];
      cap_wdata[k] = s_wdata[k*16 +: 16];
    end
    if (rst) for (int i = 0; i < NREQ; i++) sbq[i].delete();
    for (int i = 0; i < NREQ; i++) begin
      exp_v = (sbq[i].size() > 0) && (sbq[i][0].due == cyc);
      chk($sformatf("rsp_valid[%0d]@%0d", i, cyc), 32'(s_rsp_v[i]), 32'(exp_v));
      if (exp_v) begin
        chk($sformatf("rsp_data[%0d]@%0d", i, cyc), 32'(s_rsp_d[i*16 +: 16]), 32'(sbq[i][0].data));
        void'(sbq[i].pop_front());
      end else begin
        chk($sformatf("rsp_data_idle[%0d]@%0d", i, cyc), 32'(s_rsp_d[i*16 +: 16]), 32'h0);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (s_gnt[i] && bus.req_valid[i]) begin
        b = int'(bus.req_addr[i*16+1 +: 4]);
        w = int'(bus.req_addr[i*16+5 +: 11]);
        if (bus.req_we[i]) ref_mem[b][w] = bus.req_wdata[i*16 +: 16] ^ pat(b, w);
        else sbq[i].push_back('{data: ref_mem[b][w] ^ pat(b, w), due: cyc + 2});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic req(input int i, input logic we, input logic [15:0] a, input logic [15:0] d);
    bus.req_valid[i]          = 1'b1;
    bus.req_we[i]             = we;
    bus.req_addr[i*16 +: 16]  = a;
    bus.req_wdata[i*16 +: 16] = d;
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_gnt"}, 32'(s_gnt), 32'h0);
    chk({tag, "_bank_en"}, 32'(s_en), 32'h0);
    chk({tag, "_bank_we"}, 32'(s_we), 32'h0);
    chk({tag, "_bank_addr"}, 32'(|s_addr), 32'h0);
    chk({tag, "_bank_wdata"}, 32'(|s_wdata), 32'h0);
    chk({tag, "_rsp_valid"}, 32'(s_rsp_v), 32'h0);
    chk({tag, "_rsp_data"}, 32'(|s_rsp_d), 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    for (int i = 0; i < NREQ; i++) req(i, 1'b1, 16'hFFFE, 16'hFFFF);
    step();
    check_quiet("reset");
    for (int i = 0; i < NREQ; i++) req(i, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("reset_gnt_2", 32'(s_gnt), 32'h0);

    // All four hammer bank 0 from the first cycle after release.
    rst = 1'b0;
    for (int n = 0; n < 5; n++) begin
      step();
      chk($sformatf("rr_gnt_%0d", n), 32'(s_gnt), 32'h1 << (n % 4));
      chk($sformatf("rr_bank_en_%0d", n), 32'(s_en), 32'h0001);
    end
    bus.req_valid = '0;
    bus.req_we    = '1;
    step();
    chk("novalid_gnt", 32'(s_gnt), 32'h0);
    chk("novalid_bank_en", 32'(s_en), 32'h0);
    bus.req_we = '0;
    step();

    req(3, 1'b1, 16'h0004, 16'hBEEF);
    step();
    chk("wr_beef_gnt", 32'(s_gnt), 32'h8);
    chk("wr_beef_we", 32'(s_we), 32'h0004);
    chk("wr_beef_wdata", 32'(s_wdata[2*16 +: 16]), 32'hBEEF);
    bus.req_valid = '0;
    req(0, 1'b0, 16'h0004, 16'h0000);
    step();
    chk("rd_beef_gnt", 32'(s_gnt), 32'h1);
    chk("rd_beef_en", 32'(s_en), 32'h0004);
    chk("rd_beef_addr", 32'(s_addr[2*11 +: 11]), 32'h0);
    bus.req_valid = '0;
    step();
    chk("rd_beef_early", 32'(s_rsp_v), 32'h0);
    step();
    chk("rd_beef_valid", 32'(s_rsp_v), 32'h1);
    chk("rd_beef_data", 32'(s_rsp_d[15:0]), 32'hBEEF);

    for (int i = 0; i < NREQ; i++) req(i, 1'b0, 16'(2 * i), 16'h0000);
    step();
    chk("par_gnt", 32'(s_gnt), 32'hF);
    chk("par_en", 32'(s_en), 32'h000F);
    bus.req_valid = '0;
    step();

    req(1, 1'b1, 16'h0010, 16'h1234);
    step();
    chk("wr1_gnt", 32'(s_gnt), 32'h2);
    chk("wr1_en", 32'(s_en), 32'h0100);
    chk("wr1_we", 32'(s_we), 32'h0100);
    chk("wr1_wdata", 32'(s_wdata[8*16 +: 16]), 32'h1234);
    req(1, 1'b0, 16'h0010, 16'h0000);
    step();
    chk("rd1_gnt", 32'(s_gnt), 32'h2);
    chk("rd1_we", 32'(s_we), 32'h0);
    chk("rd1_en", 32'(s_en), 32'h0100);
    bus.req_valid = '0;
    step();
    chk("wr1_no_rsp", 32'(s_rsp_v), 32'h0);
    step();
    chk("rd1_valid", 32'(s_rsp_v), 32'h2);
    chk("rd1_data", 32'(s_rsp_d[16 +: 16]), 32'h1234);

    req(3, 1'b1, 16'h0F2A, 16'hCAFE);
    step();
    chk("wr3_addr", 32'(s_addr[5*11 +: 11]), 32'h079);
    chk("wr3_wdata", 32'(s_wdata[5*16 +: 16]), 32'hCAFE);
    bus.req_valid = '0;
    req(0, 1'b0, 16'h0F2A, 16'h0000);
    step();
    chk("rd3_gnt", 32'(s_gnt), 32'h1);
    bus.req_valid = '0;
    step();
    step();
    chk("rd3_data", 32'(s_rsp_d[15:0]), 32'hCAFE);

    // Bank 3 pointer is 0 here; later it sits at 3 and must wrap.
    req(0, 1'b0, 16'h0006, 16'h0000);
    req(2, 1'b0, 16'h0026, 16'h0000);
    step();
    chk("ct_gnt_a", 32'(s_gnt), 32'h1);
    bus.req_valid[0] = 1'b0;
    step();
    chk("ct_gnt_b", 32'(s_gnt), 32'h4);
    req(0, 1'b0, 16'h0006, 16'h0000);
    req(1, 1'b0, 16'h0046, 16'h0000);
    req(2, 1'b0, 16'h0086, 16'h0000);
    step();
    chk("wrap_gnt_a", 32'(s_gnt), 32'h1);
    bus.req_valid[0] = 1'b0;
    step();
    chk("wrap_gnt_b", 32'(s_gnt), 32'h2);
    bus.req_valid[1] = 1'b0;
    step();
    chk("wrap_gnt_c", 32'(s_gnt), 32'h4);
    bus.req_valid = '0;
    step();

    req(2, 1'b0, 16'h004A, 16'h0000);
    step();
    chk("b2b_gnt_0", 32'(s_gnt), 32'h4);
    req(2, 1'b0, 16'h004C, 16'h0000);
    step();
    chk("b2b_gnt_1", 32'(s_gnt), 32'h4);
    req(2, 1'b0, 16'h004E, 16'h0000);
    step();
    chk("b2b_gnt_2", 32'(s_gnt), 32'h4);
    chk("b2b_rsp_0", 32'(s_rsp_v[2]), 32'h1);
    chk("b2b_data_0", 32'(s_rsp_d[2*16 +: 16]), 32'(pat(5, 2)));
    bus.req_valid = '0;
    step();
    chk("b2b_rsp_1", 32'(s_rsp_v[2]), 32'h1);
    chk("b2b_data_1", 32'(s_rsp_d[2*16 +: 16]), 32'(pat(6, 2)));
    step();
    chk("b2b_rsp_2", 32'(s_rsp_v[2]), 32'h1);
    chk("b2b_data_2", 32'(s_rsp_d[2*16 +: 16]), 32'(pat(7, 2)));
    step();
    chk("b2b_rsp_end", 32'(s_rsp_v[2]), 32'h0);

    // Reset lands while a read is in flight; its response must never appear.
    req(0, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("pre_rst_gnt", 32'(s_gnt), 32'h1);
    bus.req_valid = '0;
    rst = 1'b1;
    for (int i = 0; i < NREQ; i++) req(i, 1'b1, 16'hFFFE, 16'hFFFF);
    step();
    check_quiet("midrst");
    for (int i = 0; i < NREQ; i++) req(i, 1'b0, 16'h0000, 16'h0000);
    step();
    chk("midrst_rsp_2", 32'(s_rsp_v), 32'h0);
    rst = 1'b0;
    step();
    chk("post_rst_gnt_0", 32'(s_gnt), 32'h1);
    step();
    chk("post_rst_gnt_1", 32'(s_gnt), 32'h2);
    bus.req_valid = '0;
    for (int n = 0; n < 3; n++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
